// File: rtl/aes_block_packer.sv
// Packs four 32-bit stream beats into one 128-bit AES block and hands it to the engine.
// A fill register plus a held output register let the next block fill while the current one waits.
module aes_block_packer #(
    parameter int IN_WIDTH    = 32,
    parameter int BLOCK_WIDTH = 128,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   start_i,
    input  logic [CNT_WIDTH-1:0]   num_blocks_i,
    input  logic                   swap_bytes_i,
    input  logic                   in_valid_i,
    input  logic [IN_WIDTH-1:0]    in_data_i,
    input  logic [IN_WIDTH/8-1:0]  in_strb_i,
    output logic                   in_ready_o,
    output logic                   blk_valid_o,
    output logic [BLOCK_WIDTH-1:0] blk_data_o,
    input  logic                   blk_ready_i,
    output logic [CNT_WIDTH-1:0]   blk_count_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   strb_err_o
);
    localparam int NBYTES = IN_WIDTH / 8;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]               state;
    logic [1:0]               word_cnt;
    logic [2:0][IN_WIDTH-1:0] fill_q;
    logic [CNT_WIDTH-1:0]     blocks_in;
    logic [CNT_WIDTH-1:0]     blocks_out;
    logic [CNT_WIDTH-1:0]     num_blocks_q;
    logic                     swap_q;
    logic [IN_WIDTH-1:0]      beat_swapped;
    logic [IN_WIDTH-1:0]      beat;
    logic                     out_free;
    logic                     out_fire;
    logic                     beat_fire;
    logic                     blk_load;

    for (genvar b = 0; b < NBYTES; b++) begin : g_swap
        assign beat_swapped[8*b +: 8] = in_data_i[8*(NBYTES-1-b) +: 8];
    end

    assign beat     = swap_q ? beat_swapped : in_data_i;
    assign out_free = !blk_valid_o || blk_ready_i;
    assign out_fire = blk_valid_o && blk_ready_i;

    // The 4th beat lands straight in the output register, so it may only
    // be taken when that register is empty or draining this cycle.
    assign in_ready_o = (state == RUN) && (blocks_in < num_blocks_q)
                        && ((word_cnt != 2'd3) || out_free);
    assign beat_fire  = in_valid_i && in_ready_o;
    assign blk_load   = beat_fire && (word_cnt == 2'd3);

    assign blk_count_o = blocks_out;
    assign busy_o      = (state == RUN) || (state == DONE);
    assign done_o      = (state == DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fill_q <= '0;
        end else if (clear) begin
            fill_q <= '0;
        end else begin
            for (int w = 0; w < 3; w++) begin
                if (beat_fire && (word_cnt == 2'(w))) fill_q[w] <= beat;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            word_cnt     <= '0;
            blocks_in    <= '0;
            blocks_out   <= '0;
            num_blocks_q <= '0;
            swap_q       <= 1'b0;
            blk_valid_o  <= 1'b0;
            blk_data_o   <= '0;
            strb_err_o   <= 1'b0;
        end else if (clear) begin
            state        <= IDLE;
            word_cnt     <= '0;
            blocks_in    <= '0;
            blocks_out   <= '0;
            num_blocks_q <= '0;
            swap_q       <= 1'b0;
            blk_valid_o  <= 1'b0;
            blk_data_o   <= '0;
            strb_err_o   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        num_blocks_q <= num_blocks_i;
                        swap_q       <= swap_bytes_i;
                        word_cnt     <= '0;
                        blocks_in    <= '0;
                        blocks_out   <= '0;
                        strb_err_o   <= 1'b0;
                        state        <= (num_blocks_i == '0) ? DONE : RUN;
                    end
                end
                RUN:     if (blocks_out == num_blocks_q) state <= DONE;
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase

            if (beat_fire) begin
                word_cnt <= word_cnt + 2'd1;
                if (in_strb_i != '1) strb_err_o <= 1'b1;
            end

            // A load in the same cycle as a drain keeps valid high with new data.
            if (blk_load) begin
                blk_data_o  <= {fill_q[0], fill_q[1], fill_q[2], beat};
                blk_valid_o <= 1'b1;
                blocks_in   <= blocks_in + CNT_WIDTH'(1);
            end else if (out_fire) begin
                blk_valid_o <= 1'b0;
            end

            if (out_fire) blocks_out <= blocks_out + CNT_WIDTH'(1);
        end
    end
endmodule
